program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time writer for the program instruction memory; the write-side counterpart of the 18-bit instruction fetch path.
- Receives a framed byte stream from the host link and assembles 18-bit instruction words.
- Writes the words to consecutive program-memory addresses.
- Holds the CPU halted until a frame is received with a correct checksum.

Parameters:
- BASE_ADDR, 16'h0000, program-memory address of the first loaded word.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between bytes inside a frame before the frame is aborted.

Ports:
- i_clock  input  1  system clock; all state changes on the rising edge.
- i_reset_n  input  1  synchronous reset, active low.
- i_byte  input  [0:7]  incoming byte; bit 0 is the MSB.
- i_byteValid  input  1  i_byte is valid this cycle.
- o_byteReady  output  1  loader accepts a byte this cycle.
- i_restart  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- o_wAddr  output  [0:15]  program-memory write address.
- o_wData  output  [0:17]  instruction word to write; bit 0 is the MSB.
- o_wEn  output  1  one-cycle write strobe.
- o_cpuHold  output  1  keeps the CPU halted while high.
- o_done  output  1  frame loaded successfully (level).
- o_error  output  1  frame rejected (level).

Behaviour:
- Reset: applied when i_reset_n is low at a rising edge. Reset wins over every other event, including in mid-frame; there is no partial-frame recovery.
  - State goes to IDLE.
  - o_cpuHold=1, o_wEn=0, o_done=0, o_error=0, o_wAddr=BASE_ADDR, o_wData=0, o_byteReady=1.
  - Checksum, word count and timeout counter are cleared.
- Handshake: a byte is accepted when i_byteValid && o_byteReady at the clock edge. o_byteReady=1 in IDLE, LEN_HI, LEN_LO, W0, W1, W2 and CSUM, and 0 in DONE and ERROR.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N words of 3 bytes each, then CSUM.
  - N = {LEN_HI, LEN_LO}, unsigned.
  - Word = {W0[6:7], W1, W2}. W0 bits [0:5] are ignored and are not checked.
  - CSUM = XOR of LEN_HI, LEN_LO and every payload byte. The sync byte is excluded.
- FSM transitions:
  - IDLE: a byte equal to SYNC_BYTE moves to LEN_HI; any other byte is discarded and the state stays IDLE. o_cpuHold stays 1.
  - LEN_HI -> LEN_LO.
  - LEN_LO: go to W0 if N != 0, otherwise go to CSUM.
  - W0 -> W1 -> W2.
  - W2: on acceptance, the next cycle has o_wEn=1 with o_wData equal to the assembled word and o_wAddr equal to the current address.
    - The address increments modulo 2^16 in the cycle after the strobe.
    - Go to W0 if words remaining > 1 after this word, otherwise go to CSUM.
    - A W0 byte may be accepted in the same cycle as o_wEn is high.
  - CSUM: if the byte matches the running XOR, go to DONE; otherwise go to ERROR.
  - DONE: o_done=1, o_cpuHold=0.
  - ERROR: o_error=1, o_cpuHold=1.
  - i_restart in DONE or ERROR: go to IDLE, clear o_done, o_error, checksum and count, set o_wAddr=BASE_ADDR and o_cpuHold=1. i_restart in any other state is ignored.
- Timeout:
  - In any state from LEN_HI through CSUM, the counter increments on every cycle with no accepted byte and clears on each accepted byte.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte accepted, go to ERROR on the next edge.
  - The counter is inactive in IDLE, DONE and ERROR.
- Sync byte mid-frame: treated as ordinary data, with no resynchronisation.
- Words already written before an ERROR are not undone. The CPU stays held regardless.
- Latency: the write strobe is exactly 1 cycle after the W2 byte is accepted. o_done rises 1 cycle after the CSUM byte is accepted.
- Address wrap: BASE_ADDR+N beyond 16'hFFFF wraps to 0 without any flag.

Decomposition:
- Shared package:
  - state encoding typedef: IDLE, LEN_HI, LEN_LO, W0, W1, W2, CSUM, DONE, ERROR.
  - SYNC_BYTE default.
  - INSTR_WIDTH=18 and ADDR_WIDTH=16, shared with the fetch path.
- One sub-module: loader_timeout.
  - Parameterised down-counter with clear and enable inputs and an expired output.
  - Counter width is derived from TIMEOUT_CYCLES.

Test Plan:
- Reset with i_reset_n low for 2 cycles -> o_cpuHold=1, o_done=0, o_error=0, o_wEn=0, o_wAddr=0.
- Frame A5,00,02,03,FF,FF,00,12,34,CSUM=00^02^03^FF^FF^00^12^34 -> two write strobes: addr 0 data 18'h3FFFF, addr 1 data 18'h01234. Then o_done=1 and o_cpuHold=0.
- Garbage bytes 00,5A,FF, then frame A5,00,00,00 -> no write strobes, o_done=1.
- Frame A5,00,01,01,02,03,CSUM=FF -> one write at addr 0 with data 18'h10203. Then o_error=1, o_cpuHold=1. A 1-cycle i_restart pulse returns to IDLE with o_error=0.
- With TIMEOUT_CYCLES=16: send A5,00,01,01, then stall -> o_error=1 exactly 16 cycles after the last accepted byte, and no write strobe.
- With BASE_ADDR=16'hFFFF: a frame with N=2 writes addr FFFF then addr 0000. i_reset_n low in the middle of a second frame -> immediately IDLE with o_cpuHold=1.

Source files
------------

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: state encoding and widths shared by the loader and the instruction fetch path
package program_loader_pkg;
  localparam int INSTR_WIDTH = 18;
  localparam int ADDR_WIDTH = 16;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, W0, W1, W2, CSUM, DONE, ERROR} state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: host byte link plus program-memory write port of the loader
// slave  (loader): takes i_byte/i_byteValid/i_restart, drives o_byteReady, write port and status
// master (host)  : the opposite directions
interface program_loader_if;
  import program_loader_pkg::*;
  logic [0:7] i_byte;
  logic i_byteValid;
  logic o_byteReady;
  logic i_restart;
  logic [0:ADDR_WIDTH-1] o_wAddr;
  logic [0:INSTR_WIDTH-1] o_wData;
  logic o_wEn;
  logic o_cpuHold;
  logic o_done;
  logic o_error;
  modport slave(input i_byte, i_byteValid, i_restart,
                output o_byteReady, o_wAddr, o_wData, o_wEn, o_cpuHold, o_done, o_error);
  modport master(output i_byte, i_byteValid, i_restart,
                 input o_byteReady, o_wAddr, o_wData, o_wEn, o_cpuHold, o_done, o_error);
endinterface

// File: rtl/program_loader_timeout.sv
// loader_timeout: idle-cycle down-counter; expired is high once CYCLES-1 idle cycles have elapsed
// clk/rst_n: clock and synchronous active-low reset; clear reloads; en counts down; expired at zero
module loader_timeout #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (!rst_n || clear) count <= LOAD;
    else if (en && count != '0) count <= count - 1'b1;
  assign expired = count == '0;
endmodule

// File: rtl/program_loader.sv
// program_loader: parses framed boot bytes into 18-bit words, writes program memory, releases the CPU on a good checksum
// i_clock/i_reset_n: clock and synchronous active-low reset
// bus: byte link in (i_byte, i_byteValid, o_byteReady, i_restart), write port out (o_wAddr, o_wData, o_wEn),
//      status out (o_cpuHold, o_done, o_error)
module program_loader import program_loader_pkg::*; #(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic i_clock,
  input logic i_reset_n,
  program_loader_if.slave bus
);
  state_t state;
  logic [7:0] csum;
  logic [15:0] count;
  logic [9:0] hold;
  logic take, active, expired;
  assign bus.o_byteReady = state != DONE && state != ERROR;
  assign take = bus.i_byteValid && bus.o_byteReady;
  assign active = state inside {LEN_HI, LEN_LO, W0, W1, W2, CSUM};
  loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(i_clock), .rst_n(i_reset_n), .clear(take || !active), .en(active && !take), .expired(expired)
  );
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= IDLE;
      csum <= '0;
      count <= '0;
      hold <= '0;
      bus.o_wAddr <= BASE_ADDR;
      bus.o_wData <= '0;
      bus.o_wEn <= 1'b0;
      bus.o_cpuHold <= 1'b1;
      bus.o_done <= 1'b0;
      bus.o_error <= 1'b0;
    end else begin
      bus.o_wEn <= 1'b0;
      // address advances in the cycle after each strobe
      if (bus.o_wEn) bus.o_wAddr <= bus.o_wAddr + 1'b1;
      if (active && !take && expired) begin
        state <= ERROR;
        bus.o_error <= 1'b1;
      end else if (take) begin
        // sync byte starts a fresh checksum; CSUM-state update is irrelevant since the frame ends there
        csum <= state == IDLE ? '0 : csum ^ bus.i_byte;
        case (state)
          IDLE: state <= bus.i_byte == SYNC_BYTE ? LEN_HI : IDLE;
          LEN_HI: begin
            count[15:8] <= bus.i_byte;
            state <= LEN_LO;
          end
          LEN_LO: begin
            count[7:0] <= bus.i_byte;
            state <= {count[15:8], bus.i_byte} != 16'd0 ? W0 : CSUM;
          end
          W0: begin
            hold[9:8] <= bus.i_byte[6:7];
            state <= W1;
          end
          W1: begin
            hold[7:0] <= bus.i_byte;
            state <= W2;
          end
          W2: begin
            bus.o_wData <= {hold, bus.i_byte};
            bus.o_wEn <= 1'b1;
            count <= count - 1'b1;
            state <= count > 16'd1 ? W0 : CSUM;
          end
          CSUM: begin
            state <= bus.i_byte == csum ? DONE : ERROR;
            bus.o_done <= bus.i_byte == csum;
            bus.o_error <= bus.i_byte != csum;
            bus.o_cpuHold <= bus.i_byte != csum;
          end
          default: ;
        endcase
      end else if (bus.i_restart && !active && state != IDLE) begin
        state <= IDLE;
        csum <= '0;
        count <= '0;
        bus.o_wAddr <= BASE_ADDR;
        bus.o_cpuHold <= 1'b1;
        bus.o_done <= 1'b0;
        bus.o_error <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: two loaders (base 0000 and FFFF) fed one byte stream, checked against a frame-parsing model
module tb_program_loader;
  import program_loader_pkg::*;
  logic clk = 0, rst_n = 0, valid = 0, restart = 0;
  logic [7:0] din = 0;
  int total = 0, bad = 0;
  logic [33:0] qa[$], qb[$];
  logic [17:0] ed[$];
  logic [7:0] stream[$];
  logic exp_ok;
  typedef struct {logic [95:0] b; int len; logic ok; int nw; logic [35:0] d;} vec_t;
  vec_t vt[5];
  program_loader_if ia();
  program_loader_if ib();
  assign ia.i_byte = din;
  assign ia.i_byteValid = valid;
  assign ia.i_restart = restart;
  assign ib.i_byte = din;
  assign ib.i_byteValid = valid;
  assign ib.i_restart = restart;
  program_loader #(.BASE_ADDR(16'h0000), .TIMEOUT_CYCLES(16)) dut_a(.i_clock(clk), .i_reset_n(rst_n), .bus(ia));
  program_loader #(.BASE_ADDR(16'hFFFF), .TIMEOUT_CYCLES(16)) dut_b(.i_clock(clk), .i_reset_n(rst_n), .bus(ib));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ia.o_wEn) qa.push_back({ia.o_wAddr, ia.o_wData});
    if (ib.o_wEn) qb.push_back({ib.o_wAddr, ib.o_wData});
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    din = b;
    valid = 1;
    tick();
    valid = 0;
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    qa.delete();
    qb.delete();
  endtask
  task automatic do_restart();
    restart = 1;
    tick();
    restart = 0;
    qa.delete();
    qb.delete();
  endtask
  // frame model: skip to sync, read length, collect words, compare checksum
  task automatic model();
    int p = 0, n;
    logic [7:0] x;
    ed.delete();
    while (p < stream.size() && stream[p] != SYNC_BYTE_DEF) p++;
    n = {stream[p+1], stream[p+2]};
    x = stream[p+1] ^ stream[p+2];
    for (int k = 0; k < n; k++) begin
      int w0, w1, w2;
      w0 = stream[p+3+3*k];
      w1 = stream[p+4+3*k];
      w2 = stream[p+5+3*k];
      x = x ^ 8'(w0) ^ 8'(w1) ^ 8'(w2);
      ed.push_back(18'((w0 % 4) * 65536 + w1 * 256 + w2));
    end
    exp_ok = stream[p+3+3*n] == x;
  endtask
  task automatic check_out(input string tag);
    chk({tag, "_na"}, qa.size(), ed.size());
    chk({tag, "_nb"}, qb.size(), ed.size());
    for (int k = 0; k < ed.size() && k < qa.size() && k < qb.size(); k++) begin
      chk({tag, "_wa"}, qa[k], {16'(k), ed[k]});
      chk({tag, "_wb"}, qb[k], {16'((65535 + k) % 65536), ed[k]});
    end
    chk({tag, "_done"}, {ia.o_done, ib.o_done}, {2{exp_ok}});
    chk({tag, "_err"}, {ia.o_error, ib.o_error}, {2{!exp_ok}});
    chk({tag, "_hold"}, {ia.o_cpuHold, ib.o_cpuHold}, {2{!exp_ok}});
    chk({tag, "_rdy"}, {ia.o_byteReady, ib.o_byteReady}, 2'b00);
  endtask
  initial begin
    vt[0] = '{96'hA5000203FFFF00123427, 10, 1'b1, 2, {18'h3FFFF, 18'h01234}};
    vt[1] = '{96'h005AFFA5000000, 7, 1'b1, 0, 36'h0};
    vt[2] = '{96'hA50001010203FF, 7, 1'b0, 1, {18'h10203, 18'h0}};
    vt[3] = '{96'hA50001A5A5A5A4, 7, 1'b1, 1, {18'h1A5A5, 18'h0}};
    vt[4] = '{96'hA5000001, 4, 1'b0, 0, 36'h0};
    tick();
    tick();
    chk("rst_hold", {ia.o_cpuHold, ib.o_cpuHold}, 2'b11);
    chk("rst_flags", {ia.o_done, ia.o_error, ia.o_wEn, ib.o_done, ib.o_error, ib.o_wEn}, 6'b0);
    chk("rst_addr", {ia.o_wAddr, ib.o_wAddr}, 32'h0000FFFF);
    chk("rst_data", ia.o_wData, 18'h0);
    chk("rst_rdy", {ia.o_byteReady, ib.o_byteReady}, 2'b11);
    foreach (vt[i]) begin
      do_reset();
      for (int j = 0; j < vt[i].len; j++) send(vt[i].b[8*(vt[i].len-1-j) +: 8]);
      ed.delete();
      for (int k = 0; k < vt[i].nw; k++) ed.push_back(k == 0 ? vt[i].d[35:18] : vt[i].d[17:0]);
      exp_ok = vt[i].ok;
      check_out($sformatf("vec%0d", i));
    end
    do_reset();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h03); send(8'hFF);
    chk("lat_pre", ia.o_wEn, 1'b0);
    send(8'hFF);
    chk("lat_w0", {ia.o_wEn, ia.o_wAddr, ia.o_wData}, {1'b1, 16'h0000, 18'h3FFFF});
    chk("lat_w0b", {ib.o_wEn, ib.o_wAddr}, {1'b1, 16'hFFFF});
    send(8'h00);
    chk("addr_inc", {ia.o_wEn, ia.o_wAddr, ib.o_wAddr}, {1'b0, 16'h0001, 16'h0000});
    send(8'h12);
    send(8'h34);
    chk("lat_w1", {ia.o_wEn, ia.o_wAddr, ia.o_wData}, {1'b1, 16'h0001, 18'h01234});
    chk("pre_done", ia.o_done, 1'b0);
    send(8'h27);
    chk("lat_done", {ia.o_done, ia.o_cpuHold, ib.o_done, ib.o_cpuHold}, 4'b1010);
    do_restart();
    chk("rs_flags", {ia.o_done, ia.o_error, ia.o_cpuHold, ia.o_byteReady}, 4'b0011);
    chk("rs_addr", {ia.o_wAddr, ib.o_wAddr}, 32'h0000FFFF);
    send(8'hA5); send(8'h00);
    do_restart();
    send(8'h00); send(8'h00);
    chk("rs_ignored", {ia.o_done, ib.o_done}, 2'b11);
    do_reset();
    send(8'hA5); send(8'h00); send(8'h01); send(8'h01);
    begin
      int c = 0;
      while (c < 40 && !ia.o_error) begin
        tick();
        c++;
      end
      chk("to_cycles", c, 16);
      chk("to_err", {ia.o_error, ib.o_error, ia.o_cpuHold}, 3'b111);
      chk("to_nowr", qa.size() + qb.size(), 0);
    end
    do_restart();
    send(8'hA5); send(8'h00); send(8'h02); send(8'h01); send(8'h02);
    rst_n = 0;
    tick();
    chk("mid_rst", {ia.o_cpuHold, ia.o_byteReady, ia.o_done, ia.o_error}, 4'b1100);
    chk("mid_rst_addr", {ia.o_wAddr, ib.o_wAddr}, 32'h0000FFFF);
    rst_n = 1;
    qa.delete();
    qb.delete();
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    chk("mid_rst_idle", {ia.o_done, ib.o_done, qa.size() == 0}, 3'b111);
    do_restart();
    for (int it = 0; it < 30; it++) begin
      int n;
      logic [7:0] x, g;
      stream.delete();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        stream.push_back(g == SYNC_BYTE_DEF ? 8'h00 : g);
      end
      n = $urandom_range(0, 4);
      stream.push_back(SYNC_BYTE_DEF);
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      x = 8'(n);
      repeat (3 * n) begin
        g = 8'($urandom);
        stream.push_back(g);
        x = x ^ g;
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
      stream.push_back(x);
      foreach (stream[j]) begin
        send(stream[j]);
        repeat ($urandom_range(0, 4)) tick();
      end
      model();
      check_out($sformatf("rnd%0d", it));
      do_restart();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
